// File: rtl/placar_comparador_pkg.sv
// placar_comparador_pkg: shared state encoding, defaults and one-hot check
package placar_comparador_pkg;
    localparam int CNT_W_DEF    = 8;
    localparam int STREAK_N_DEF = 3;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONTANDO = 2'd1,
        SATURADO = 2'd2
    } estado_t;

    function automatic logic one_hot3(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100);
    endfunction
endpackage

// File: rtl/placar_comparador_if.sv
// placar_comparador_if: comparator result strobe in, statistics out
interface placar_comparador_if #(parameter int CNT_W = 8);
    logic             valid_in;
    logic             maior;
    logic             menor;
    logic             igual;
    logic             limpar;
    logic [CNT_W-1:0] cnt_maior;
    logic [CNT_W-1:0] cnt_menor;
    logic [CNT_W-1:0] cnt_igual;
    logic [CNT_W-1:0] total;
    logic             sequencia;
    logic             saturado;
    logic             erro;
    logic             ativo;

    modport master (
        output valid_in, maior, menor, igual, limpar,
        input  cnt_maior, cnt_menor, cnt_igual, total, sequencia, saturado, erro, ativo
    );
    modport slave (
        input  valid_in, maior, menor, igual, limpar,
        output cnt_maior, cnt_menor, cnt_igual, total, sequencia, saturado, erro, ativo
    );
endinterface

// File: rtl/placar_comparador_contador_sat.sv
// contador_sat: saturating up-counter with sync clear, enable and at_max flag
module contador_sat #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         at_max
);
    assign at_max = &q;

    // count up on enable, hold at all-ones, clear has priority
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en && !at_max)
            q <= q + 1'b1;
endmodule

// File: rtl/placar_comparador.sv
// placar_comparador: scoreboard of comparator outcomes with streak, saturation and error tracking
module placar_comparador
    import placar_comparador_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int STREAK_N = STREAK_N_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    placar_comparador_if.slave  bus
);
    localparam int RW = $clog2(STREAK_N + 1);
    localparam logic [CNT_W-1:0] MAX     = '1;
    localparam logic [CNT_W-1:0] QUASE   = MAX - CNT_W'(1);
    localparam logic [RW-1:0]    RUN_MAX = RW'(STREAK_N);

    estado_t       estado;
    logic [RW-1:0] run;
    logic [RW-1:0] run_nx;
    logic [2:0]    flags;
    logic          valido;
    logic          aceita;
    logic          invalido;
    logic          cheio;
    logic          max_maior, max_menor, max_igual, max_total;

    assign flags    = {bus.maior, bus.menor, bus.igual};
    assign valido   = one_hot3(flags);
    assign cheio    = max_maior | max_menor | max_igual | max_total;
    assign aceita   = bus.valid_in && valido && (estado != SATURADO) && !cheio;
    assign invalido = bus.valid_in && !valido;

    // next igual run length for an accepted sample, saturating at STREAK_N
    always_comb
        run_nx = !aceita ? run : !bus.igual ? '0 : (run == RUN_MAX) ? run : run + 1'b1;

    contador_sat #(.W(CNT_W)) u_maior (.clk(clk), .rst_n(rst_n), .clr(bus.limpar),
        .en(aceita && bus.maior), .q(bus.cnt_maior), .at_max(max_maior));
    contador_sat #(.W(CNT_W)) u_menor (.clk(clk), .rst_n(rst_n), .clr(bus.limpar),
        .en(aceita && bus.menor), .q(bus.cnt_menor), .at_max(max_menor));
    contador_sat #(.W(CNT_W)) u_igual (.clk(clk), .rst_n(rst_n), .clr(bus.limpar),
        .en(aceita && bus.igual), .q(bus.cnt_igual), .at_max(max_igual));
    contador_sat #(.W(CNT_W)) u_total (.clk(clk), .rst_n(rst_n), .clr(bus.limpar),
        .en(aceita), .q(bus.total), .at_max(max_total));

    // state machine, streak and sticky error; total hits max first so it alone decides saturation
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            estado        <= OCIOSO;
            run           <= '0;
            bus.sequencia <= 1'b0;
            bus.saturado  <= 1'b0;
            bus.erro      <= 1'b0;
            bus.ativo     <= 1'b0;
        end else if (bus.limpar) begin
            estado        <= OCIOSO;
            run           <= '0;
            bus.sequencia <= 1'b0;
            bus.saturado  <= 1'b0;
            bus.erro      <= 1'b0;
            bus.ativo     <= 1'b0;
        end else begin
            if (invalido)
                bus.erro <= 1'b1;
            if (invalido && estado != SATURADO) begin
                run           <= '0;
                bus.sequencia <= 1'b0;
            end else if (aceita) begin
                run           <= run_nx;
                bus.sequencia <= (run_nx == RUN_MAX);
                estado        <= (bus.total == QUASE) ? SATURADO : CONTANDO;
                bus.saturado  <= (bus.total == QUASE);
                bus.ativo     <= (bus.total != QUASE);
            end
        end
endmodule

// File: tb/tb_placar_comparador.sv
// tb_placar_comparador: directed checks of counting, streak, error, saturation and async reset
module tb_placar_comparador;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    placar_comparador_if #(.CNT_W(8)) ia ();
    placar_comparador_if #(.CNT_W(3)) ib ();

    placar_comparador #(.CNT_W(8), .STREAK_N(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    placar_comparador #(.CNT_W(3), .STREAK_N(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    function automatic logic [35:0] snap_a();
        return {ia.cnt_maior, ia.cnt_menor, ia.cnt_igual, ia.total,
                ia.sequencia, ia.saturado, ia.erro, ia.ativo};
    endfunction

    function automatic logic [15:0] snap_b();
        return {ib.cnt_maior, ib.cnt_menor, ib.cnt_igual, ib.total,
                ib.sequencia, ib.saturado, ib.erro, ib.ativo};
    endfunction

    function automatic logic [35:0] exp_a(int m, int n, int i, int t, logic s, logic sat, logic e, logic at);
        return {8'(m), 8'(n), 8'(i), 8'(t), s, sat, e, at};
    endfunction

    function automatic logic [15:0] exp_b(int m, int n, int i, int t, logic s, logic sat, logic e, logic at);
        return {3'(m), 3'(n), 3'(i), 3'(t), s, sat, e, at};
    endfunction

    function automatic logic [2:0] cmp(int a, int b);
        return {a > b, a < b, a == b};
    endfunction

    task automatic drive_a(input logic v, input logic [2:0] f, input logic l);
        ia.valid_in = v;
        {ia.maior, ia.menor, ia.igual} = f;
        ia.limpar = l;
        @(posedge clk);
        #1;
        ia.valid_in = 1'b0;
        ia.limpar = 1'b0;
    endtask

    task automatic drive_b(input logic v, input logic [2:0] f, input logic l);
        ib.valid_in = v;
        {ib.maior, ib.menor, ib.igual} = f;
        ib.limpar = l;
        @(posedge clk);
        #1;
        ib.valid_in = 1'b0;
        ib.limpar = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++;
        if (snap_a() !== exp_a(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL reset_a got=%h exp=%h", snap_a(), exp_a(0, 0, 0, 0, 0, 0, 0, 0));
        end
        n_chk++;
        if (snap_b() !== exp_b(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL reset_b got=%h exp=%h", snap_b(), exp_b(0, 0, 0, 0, 0, 0, 0, 0));
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_main();
        drive_a(1'b1, cmp(10, 10), 1'b0);
        n_chk++;
        if (snap_a() !== exp_a(0, 0, 1, 1, 0, 0, 0, 1)) begin
            n_bad++;
            $display("FAIL main_first got=%h exp=%h", snap_a(), exp_a(0, 0, 1, 1, 0, 0, 0, 1));
        end
        drive_a(1'b1, cmp(5, 3), 1'b0);
        drive_a(1'b1, cmp(2, 12), 1'b0);
        drive_a(1'b1, cmp(15, 0), 1'b0);
        drive_a(1'b1, cmp(0, 15), 1'b0);
        n_chk++;
        if (snap_a() !== exp_a(2, 2, 1, 5, 0, 0, 0, 1)) begin
            n_bad++;
            $display("FAIL main_five got=%h exp=%h", snap_a(), exp_a(2, 2, 1, 5, 0, 0, 0, 1));
        end
    endtask

    task automatic test_streak();
        drive_a(1'b0, 3'b000, 1'b1);
        n_chk++;
        if (snap_a() !== exp_a(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL streak_clear got=%h exp=%h", snap_a(), exp_a(0, 0, 0, 0, 0, 0, 0, 0));
        end
        drive_a(1'b1, 3'b001, 1'b0);
        drive_a(1'b0, 3'b000, 1'b0);
        drive_a(1'b1, 3'b001, 1'b0);
        n_chk++;
        if (snap_a() !== exp_a(0, 0, 2, 2, 0, 0, 0, 1)) begin
            n_bad++;
            $display("FAIL streak_two got=%h exp=%h", snap_a(), exp_a(0, 0, 2, 2, 0, 0, 0, 1));
        end
        drive_a(1'b0, 3'b001, 1'b0);
        drive_a(1'b1, 3'b001, 1'b0);
        n_chk++;
        if (snap_a() !== exp_a(0, 0, 3, 3, 1, 0, 0, 1)) begin
            n_bad++;
            $display("FAIL streak_three got=%h exp=%h", snap_a(), exp_a(0, 0, 3, 3, 1, 0, 0, 1));
        end
        drive_a(1'b0, 3'b100, 1'b0);
        n_chk++;
        if (snap_a() !== exp_a(0, 0, 3, 3, 1, 0, 0, 1)) begin
            n_bad++;
            $display("FAIL streak_gap got=%h exp=%h", snap_a(), exp_a(0, 0, 3, 3, 1, 0, 0, 1));
        end
        drive_a(1'b1, 3'b100, 1'b0);
        n_chk++;
        if (snap_a() !== exp_a(1, 0, 3, 4, 0, 0, 0, 1)) begin
            n_bad++;
            $display("FAIL streak_break got=%h exp=%h", snap_a(), exp_a(1, 0, 3, 4, 0, 0, 0, 1));
        end
    endtask

    task automatic test_erro();
        drive_a(1'b1, 3'b001, 1'b0);
        drive_a(1'b1, 3'b110, 1'b0);
        n_chk++;
        if (snap_a() !== exp_a(1, 0, 4, 5, 0, 0, 1, 1)) begin
            n_bad++;
            $display("FAIL erro_multi got=%h exp=%h", snap_a(), exp_a(1, 0, 4, 5, 0, 0, 1, 1));
        end
        drive_a(1'b1, 3'b000, 1'b0);
        n_chk++;
        if (snap_a() !== exp_a(1, 0, 4, 5, 0, 0, 1, 1)) begin
            n_bad++;
            $display("FAIL erro_none got=%h exp=%h", snap_a(), exp_a(1, 0, 4, 5, 0, 0, 1, 1));
        end
        drive_a(1'b1, 3'b001, 1'b0);
        drive_a(1'b1, 3'b001, 1'b0);
        n_chk++;
        if (snap_a() !== exp_a(1, 0, 6, 7, 0, 0, 1, 1)) begin
            n_bad++;
            $display("FAIL erro_run_reset got=%h exp=%h", snap_a(), exp_a(1, 0, 6, 7, 0, 0, 1, 1));
        end
        drive_a(1'b1, 3'b001, 1'b0);
        n_chk++;
        if (snap_a() !== exp_a(1, 0, 7, 8, 1, 0, 1, 1)) begin
            n_bad++;
            $display("FAIL erro_run_again got=%h exp=%h", snap_a(), exp_a(1, 0, 7, 8, 1, 0, 1, 1));
        end
        drive_a(1'b0, 3'b000, 1'b1);
        drive_a(1'b0, 3'b000, 1'b0);
        n_chk++;
        if (snap_a() !== exp_a(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL erro_clear got=%h exp=%h", snap_a(), exp_a(0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_saturate();
        for (int k = 1; k <= 8; k++) begin
            drive_b(1'b1, 3'b100, 1'b0);
            n_chk++;
            if (snap_b() !== exp_b(k > 7 ? 7 : k, 0, 0, k > 7 ? 7 : k, 0, k >= 7, 0, k < 7)) begin
                n_bad++;
                $display("FAIL sat_step%0d got=%h exp=%h", k, snap_b(),
                         exp_b(k > 7 ? 7 : k, 0, 0, k > 7 ? 7 : k, 0, k >= 7, 0, k < 7));
            end
        end
        drive_b(1'b1, 3'b011, 1'b0);
        n_chk++;
        if (snap_b() !== exp_b(7, 0, 0, 7, 0, 1, 1, 0)) begin
            n_bad++;
            $display("FAIL sat_erro got=%h exp=%h", snap_b(), exp_b(7, 0, 0, 7, 0, 1, 1, 0));
        end
        drive_b(1'b1, 3'b100, 1'b1);
        n_chk++;
        if (snap_b() !== exp_b(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL sat_clear_prio got=%h exp=%h", snap_b(), exp_b(0, 0, 0, 0, 0, 0, 0, 0));
        end
        drive_b(1'b1, 3'b100, 1'b0);
        n_chk++;
        if (snap_b() !== exp_b(1, 0, 0, 1, 0, 0, 0, 1)) begin
            n_bad++;
            $display("FAIL sat_restart got=%h exp=%h", snap_b(), exp_b(1, 0, 0, 1, 0, 0, 0, 1));
        end
    endtask

    task automatic test_async_reset();
        drive_a(1'b1, 3'b100, 1'b0);
        drive_a(1'b1, 3'b100, 1'b0);
        n_chk++;
        if (snap_a() !== exp_a(2, 0, 0, 2, 0, 0, 0, 1)) begin
            n_bad++;
            $display("FAIL arst_pre got=%h exp=%h", snap_a(), exp_a(2, 0, 0, 2, 0, 0, 0, 1));
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (snap_a() !== exp_a(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL arst_a got=%h exp=%h", snap_a(), exp_a(0, 0, 0, 0, 0, 0, 0, 0));
        end
        n_chk++;
        if (snap_b() !== exp_b(0, 0, 0, 0, 0, 0, 0, 0)) begin
            n_bad++;
            $display("FAIL arst_b got=%h exp=%h", snap_b(), exp_b(0, 0, 0, 0, 0, 0, 0, 0));
        end
        #2 rst_n = 1'b1;
        drive_a(1'b1, 3'b100, 1'b0);
        n_chk++;
        if (snap_a() !== exp_a(1, 0, 0, 1, 0, 0, 0, 1)) begin
            n_bad++;
            $display("FAIL arst_restart got=%h exp=%h", snap_a(), exp_a(1, 0, 0, 1, 0, 0, 0, 1));
        end
    endtask

    initial begin
        {ia.valid_in, ia.maior, ia.menor, ia.igual, ia.limpar} = '0;
        {ib.valid_in, ib.maior, ib.menor, ib.igual, ib.limpar} = '0;
        #12;
        test_reset();
        test_main();
        test_streak();
        test_erro();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/placar_comparador.md
Name: placar_comparador

Overview:
- Downstream consumer of the 4-bit structural comparator. Samples its one-hot {maior, menor, igual} result whenever an upstream valid strobe is high.
- Keeps saturating per-outcome counters, a total, a consecutive-equal streak detector, and a sticky protocol-error flag.
- A small state machine gates counting (idle / counting / saturated). Software-style clear restarts statistics.

Parameters:
- CNT_W, 8, width of each outcome counter and of total (saturating at 2^CNT_W-1)
- STREAK_N, 3, consecutive valid igual samples needed to raise sequencia (1..2^CNT_W-1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_in  input  1  comparator result valid this cycle
- maior  input  1  comparator a>b flag
- menor  input  1  comparator a<b flag
- igual  input  1  comparator a==b flag
- limpar  input  1  synchronous clear of all statistics
- cnt_maior  output  CNT_W  count of accepted maior samples
- cnt_menor  output  CNT_W  count of accepted menor samples
- cnt_igual  output  CNT_W  count of accepted igual samples
- total  output  CNT_W  count of all accepted samples
- sequencia  output  1  high while current igual run length >= STREAK_N
- saturado  output  1  high in SATURADO state
- erro  output  1  sticky: a valid sample had non-one-hot flags
- ativo  output  1  high in CONTANDO state

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous, active-low. All state is cleared immediately on rst_n low, regardless of clk.
- Reset values: all counters 0, run length 0, sequencia 0, saturado 0, erro 0, ativo 0, state OCIOSO.
- All outputs are registered. A sample accepted at edge k is visible after edge k, giving 1-cycle latency.
- Accepted sample: valid_in=1, exactly one of {maior, menor, igual} = 1, and state is OCIOSO or CONTANDO.
- Invalid sample: valid_in=1 with zero flags or more than one flag.
  - Sets erro (sticky until limpar or reset).
  - Resets run length to 0.
  - Does not touch any counter.
  - Causes no state change.
- valid_in=0 cycles: no effect. They do not break an igual run.
- States:
  - OCIOSO: after reset or limpar. On the first accepted sample, count it and go to CONTANDO.
  - CONTANDO: ativo=1. Count accepted samples. If any counter or total would reach 2^CNT_W-1 on this update, store that value and go to SATURADO.
  - SATURADO: saturado=1, ativo=0. All counters and the run length freeze. Valid samples are ignored, but invalid samples still set erro. Leave only via limpar or reset.
- Counting on an accepted sample:
  - Matching counter +1 and total +1, in the same edge.
  - Never wrap: saturate at max. Because total >= every per-outcome counter, total saturates first or together with them.
- Streak:
  - Accepted igual: run +1, saturating at STREAK_N.
  - Accepted maior or menor: run = 0.
  - sequencia = (run >= STREAK_N), registered with the counters.
- limpar=1 on an edge:
  - Zeroes counters, run, erro, sequencia and saturado; state goes to OCIOSO.
  - Has priority over a simultaneous valid_in; that sample is dropped.
- Reset asserted mid-operation behaves exactly like power-on reset. No partial updates survive.

Decomposition:
- Shared package/header: state encodings (OCIOSO=2'd0, CONTANDO=2'd1, SATURADO=2'd2); default CNT_W and STREAK_N; a one-hot-check constant/function for 3-bit flags.
- One natural sub-module: contador_sat, a parameterised saturating up-counter with sync clear, enable and an at_max flag. Instantiate it four times (three outcomes plus total).
- FSM and streak logic stay in the top.

Test Plan:
- Feed the comparator results for pairs (10,10), (5,3), (2,12), (15,0), (0,15), one per cycle, with valid_in=1 → cnt_igual=1, cnt_maior=2, cnt_menor=2, total=5, erro=0, ativo=1, sequencia=0.
- Send 3 valid igual samples with a valid_in=0 gap between them, then 1 maior → sequencia rises 1 cycle after the 3rd igual and drops 1 cycle after the maior; cnt_igual=3.
- Send valid_in=1 with flags 3'b110, then flags 3'b000 → erro=1 and stays 1, counters unchanged, run reset. Then pulse limpar → erro=0, state OCIOSO.
- With CNT_W=3, send 8 maior samples → total and cnt_maior stop at 7, saturado=1 after the 7th sample, the 8th is ignored. limpar with valid_in=1 in the same cycle → all zero, that sample not counted.
- Drive rst_n low asynchronously between clock edges mid-count → all outputs 0 immediately, before the next clk edge. After release, counting restarts from 0.
